matmul_apb_slave: RTL



---
 rtl/matmul_pkg.sv | 42 ++++
 rtl/matmul_strb_reg.sv | 35 +++
 rtl/matmul_apb_slave.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared constants for the matmul APB front-end: register offsets, control
// field layout and the bus-phase state type.
package matmul_pkg;

    // Register offsets within paddr[4:0]
    localparam logic [4:0] OffCtrl   = 5'h00;
    localparam logic [4:0] OffA      = 5'h04;
    localparam logic [4:0] OffB      = 5'h08;
    localparam logic [4:0] OffFlags  = 5'h0C;
    localparam logic [4:0] OffSpBase = 5'h10;

    // Control register field positions
    localparam int unsigned CtrlStartBit = 0;
    localparam int unsigned CtrlModeBit  = 1;
    localparam int unsigned CtrlDestLsb  = 2;
    localparam int unsigned CtrlCLsb     = 4;
    localparam int unsigned CtrlNLsb     = 8;
    localparam int unsigned CtrlKLsb     = 10;
    localparam int unsigned CtrlMLsb     = 12;
    localparam int unsigned CtrlWidth    = 14;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StWait,
        StDone
    } apb_state_e;

    // Bits of the control register that hold state; start and reserved bits read 0
    function automatic logic [CtrlWidth-1:0] ctrl_writable_mask();
        logic [CtrlWidth-1:0] m;
        m = '0;
        m[CtrlModeBit]      = 1'b1;
        m[CtrlDestLsb +: 2] = 2'b11;
        m[CtrlCLsb +: 2]    = 2'b11;
        m[CtrlNLsb +: 2]    = 2'b11;
        m[CtrlKLsb +: 2]    = 2'b11;
        m[CtrlMLsb +: 2]    = 2'b11;
        return m;
    endfunction

endpackage

// File: rtl/matmul_strb_reg.sv
// Bus-width register with per-byte write enables; unstrobed bytes hold.
module matmul_strb_reg
    import matmul_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [BUS_WIDTH/8-1:0] strb,
    input  logic [BUS_WIDTH-1:0]   wdata,
    output logic [BUS_WIDTH-1:0]   q
);

    logic [BUS_WIDTH-1:0] q_q, q_d;

    // Merge strobed bytes of the write data into the held value
    always_comb begin
        q_d = q_q;
        if (we) begin
            for (int b = 0; b < BUS_WIDTH / 8; b++) begin
                if (strb[b]) q_d[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
    end

    // Storage with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/matmul_apb_slave.sv
// APB completer for the matmul accelerator: operand banks, control register,
// start pulse generation and scratchpad result reads. Every transfer takes one
// wait state, so pready rises on the second penable cycle.
module matmul_apb_slave
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned BUS_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
    parameter int unsigned SP_NTARGETS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_WIDTH-1:0]        paddr,
    input  logic [BUS_WIDTH-1:0]         pwdata,
    input  logic [BUS_WIDTH/8-1:0]       pstrb,
    output logic                         pready,
    output logic [BUS_WIDTH-1:0]         prdata,
    output logic                         pslverr,
    output logic                         start,
    output logic [13:0]                  ctrl_cfg,
    output logic [MAX_DIM*BUS_WIDTH-1:0] mat_a,
    output logic [MAX_DIM*BUS_WIDTH-1:0] mat_b,
    input  logic                         core_busy,
    input  logic [BUS_WIDTH-1:0]         core_flags,
    output logic                         sp_rd_en,
    output logic [1:0]                   sp_target,
    output logic [ADDR_WIDTH-6:0]        sp_idx,
    input  logic [BUS_WIDTH-1:0]         sp_rdata
);

    localparam int unsigned          IdxW       = ADDR_WIDTH - 5;
    localparam logic [IdxW-1:0]      AbIdxLimit = IdxW'(MAX_DIM);
    localparam logic [IdxW-1:0]      SpIdxLimit = IdxW'(MAX_DIM * MAX_DIM);
    localparam logic [BUS_WIDTH-1:0] CtrlMask   = BUS_WIDTH'(ctrl_writable_mask());

    // Address decode
    logic [4:0]      offset;
    logic [IdxW-1:0] idx;
    logic            is_ctrl, is_a, is_b, is_flags, is_sp;

    assign offset   = paddr[4:0];
    assign idx      = paddr[ADDR_WIDTH-1:5];
    assign is_ctrl  = (offset == OffCtrl);
    assign is_a     = (offset == OffA);
    assign is_b     = (offset == OffB);
    assign is_flags = (offset == OffFlags);
    assign is_sp    = (offset >= OffSpBase) && (offset[1:0] == 2'b00)
                      && (32'(offset[3:2]) < SP_NTARGETS);

    // Bus phase tracking
    apb_state_e state_q, state_d;
    logic       in_wait, in_done;

    // Per-transfer captures
    logic                 err_q, sp_sel_q, start_q, start_d;
    logic [BUS_WIDTH-1:0] rdata_q;

    // Register banks
    logic [BUS_WIDTH-1:0] ctrl_q;
    logic [BUS_WIDTH-1:0] a_q [MAX_DIM];
    logic [BUS_WIDTH-1:0] b_q [MAX_DIM];
    logic                 commit, ctrl_we;
    logic [MAX_DIM-1:0]   a_we, b_we;

    // Start and reserved bits are never stored, so they read back as 0
    matmul_strb_reg #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_ctrl_reg (
        .clk   (clk),
        .rst   (rst),
        .we    (ctrl_we),
        .strb  (pstrb),
        .wdata (pwdata & CtrlMask),
        .q     (ctrl_q)
    );

    for (genvar i = 0; i < MAX_DIM; i++) begin : g_bank
        assign a_we[i] = commit && is_a && (idx == IdxW'(i));
        assign b_we[i] = commit && is_b && (idx == IdxW'(i));

        matmul_strb_reg #(
            .BUS_WIDTH (BUS_WIDTH)
        ) u_a_reg (
            .clk   (clk),
            .rst   (rst),
            .we    (a_we[i]),
            .strb  (pstrb),
            .wdata (pwdata),
            .q     (a_q[i])
        );

        matmul_strb_reg #(
            .BUS_WIDTH (BUS_WIDTH)
        ) u_b_reg (
            .clk   (clk),
            .rst   (rst),
            .we    (b_we[i]),
            .strb  (pstrb),
            .wdata (pwdata),
            .q     (b_q[i])
        );

        assign mat_a[i*BUS_WIDTH +: BUS_WIDTH] = a_q[i];
        assign mat_b[i*BUS_WIDTH +: BUS_WIDTH] = b_q[i];
    end

    // Error and read value for the access currently on the bus
    logic                 err_now;
    logic [BUS_WIDTH-1:0] rd_now;

    always_comb begin
        err_now = 1'b1;
        rd_now  = '0;
        if (is_ctrl) begin
            err_now = pwrite && core_busy;
            rd_now  = ctrl_q;
        end else if (is_a || is_b) begin
            err_now = (idx >= AbIdxLimit) || (pwrite && core_busy);
            for (int i = 0; i < MAX_DIM; i++) begin
                if (idx == IdxW'(i)) rd_now = is_a ? a_q[i] : b_q[i];
            end
        end else if (is_flags) begin
            err_now = pwrite;
            rd_now  = core_flags;
        end else if (is_sp) begin
            err_now = pwrite || (idx >= SpIdxLimit);
        end
        if (pwrite || err_now) rd_now = '0;
    end

    // Next phase: state_q holds the previous cycle's phase, state_d is this cycle's
    always_comb begin
        state_d = StIdle;
        case (state_q)
            StIdle, StDone: if (psel && !penable) state_d = StSetup;
            StSetup:        if (psel && penable)  state_d = StWait;
            StWait:         if (psel && penable)  state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    assign in_wait = (state_d == StWait);
    assign in_done = (state_d == StDone);
    assign commit  = in_done && pwrite && !err_q;
    assign ctrl_we = commit && is_ctrl;
    assign start_d = ctrl_we && pstrb[0] && pwdata[CtrlStartBit];

    // Phase register; decode results sampled in WAIT and held for DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            sp_sel_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            if (in_wait) begin
                err_q    <= err_now;
                sp_sel_q <= is_sp;
                rdata_q  <= rd_now;
            end
        end
    end

    assign pready    = in_done;
    assign pslverr   = in_done && err_q;
    assign prdata    = (in_done && !err_q) ? (sp_sel_q ? sp_rdata : rdata_q) : '0;
    assign start     = start_q;
    assign ctrl_cfg  = ctrl_q[CtrlWidth-1:0];
    assign sp_rd_en  = in_wait && !pwrite && is_sp && !err_now;
    assign sp_target = offset[3:2];
    assign sp_idx    = idx;

endmodule
